// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the 1280x800 @ 60 Hz mode, used by the
// timing generator and the renderer.
package vga_timing_gen_pkg;

  localparam int VGA_H_ACTIVE   = 1280;
  localparam int VGA_H_FP       = 72;
  localparam int VGA_H_SYNC     = 128;
  localparam int VGA_H_BP       = 200;
  localparam int VGA_V_ACTIVE   = 800;
  localparam int VGA_V_FP       = 3;
  localparam int VGA_V_SYNC     = 6;
  localparam int VGA_V_BP       = 22;
  localparam bit VGA_H_POL      = 1'b0;
  localparam bit VGA_V_POL      = 1'b1;
  localparam int VGA_SYNC_DELAY = 1;

  localparam int VGA_X_W = 11;
  localparam int VGA_Y_W = 10;

  // Sync pair carried through the delay pipe.
  typedef struct packed {
    logic vs;
    logic hs;
  } sync_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Parameterised shift register with a reset-to-value input. DEPTH = 0
// degenerates to a wire so the syncs come straight off the aligned registers.
module sync_delay #(
  parameter int W     = 2,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, rst_val};
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    // Shift one stage per clock, newest sample enters stage 0.
    always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Reset flushes every stage to the idle level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= {DEPTH{rst_val}};
      else     pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel/line counters, aligned coordinate and flag
// stream for the renderer, and delayed hsync/vsync for the connector.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit H_POL      = VGA_H_POL,
  parameter bit V_POL      = VGA_V_POL,
  parameter int SYNC_DELAY = VGA_SYNC_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  output logic [VGA_X_W-1:0] curr_x,
  output logic [VGA_Y_W-1:0] curr_y,
  output logic               active_area,
  output logic               vblank,
  output logic               frame_start,
  output logic               vga_hsync,
  output logic               vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0 || SYNC_DELAY < 0 || SYNC_DELAY > 7)
  begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  // Width-matched window bounds so every compare is a plain unsigned one.
  localparam logic [VGA_X_W-1:0] H_ACT_C  = VGA_X_W'(H_ACTIVE);
  localparam logic [VGA_X_W-1:0] H_SS_C   = VGA_X_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_X_W-1:0] H_SE_C   = VGA_X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VGA_X_W-1:0] H_LAST_C = VGA_X_W'(H_TOTAL - 1);
  localparam logic [VGA_Y_W-1:0] V_ACT_C  = VGA_Y_W'(V_ACTIVE);
  localparam logic [VGA_Y_W-1:0] V_SS_C   = VGA_Y_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_Y_W-1:0] V_SE_C   = VGA_Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VGA_Y_W-1:0] V_LAST_C = VGA_Y_W'(V_TOTAL - 1);

  localparam sync_t SYNC_IDLE = '{vs: ~V_POL, hs: ~H_POL};

  logic [VGA_X_W-1:0] hc_q, hc_d;
  logic [VGA_Y_W-1:0] vc_q, vc_d;
  logic               started_q, started_d;
  logic               active_q, active_d;
  logic               vblank_q, vblank_d;
  logic               fstart_q, fstart_d;
  sync_t              sync_raw, sync_out;

  // Counter advance. The first edge after reset presents (0,0) instead of
  // advancing, which is what distinguishes it from the reset state.
  always_comb begin
    started_d = 1'b1;
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (!started_q) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_LAST_C) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST_C) ? '0 : vc_q + 1'b1;
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // Flags are derived from the next coordinate so they land with it.
  always_comb begin
    active_d = (hc_d < H_ACT_C) && (vc_d < V_ACT_C);
    vblank_d = (vc_d >= V_ACT_C);
    fstart_d = (hc_d == '0) && (vc_d == '0);
  end

  // Coordinate and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_q      <= '0;
      vc_q      <= '0;
      started_q <= 1'b0;
      active_q  <= 1'b0;
      vblank_q  <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      started_q <= started_d;
      active_q  <= active_d;
      vblank_q  <= vblank_d;
      fstart_q  <= fstart_d;
    end
  end

  // Undelayed sync levels for the presented coordinate; idle until started.
  always_comb begin
    sync_raw    = SYNC_IDLE;
    if (started_q && hc_q >= H_SS_C && hc_q <= H_SE_C) sync_raw.hs = H_POL;
    if (started_q && vc_q >= V_SS_C && vc_q <= V_SE_C) sync_raw.vs = V_POL;
  end

  sync_delay #(
    .W     (2),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk     (clk),
    .rst     (rst),
    .rst_val (SYNC_IDLE),
    .din     (sync_raw),
    .dout    (sync_out)
  );

  assign curr_x      = hc_q;
  assign curr_y      = vc_q;
  assign active_area = active_q;
  assign vblank      = vblank_q;
  assign frame_start = fstart_q;
  assign vga_hsync   = sync_out.hs;
  assign vga_vsync   = sync_out.vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode (first line), SYNC_DELAY=3 variant, and the
// small 14x7 configuration for full-frame, period and mid-frame reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst, rst_sm;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // default configuration, SYNC_DELAY=1
  logic [10:0] x_a; logic [9:0] y_a; logic act_a, vb_a, fs_a, hs_a, vs_a;
  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .curr_x(x_a), .curr_y(y_a), .active_area(act_a),
    .vblank(vb_a), .frame_start(fs_a), .vga_hsync(hs_a), .vga_vsync(vs_a)
  );

  // default configuration, SYNC_DELAY=3
  logic [10:0] x_b; logic [9:0] y_b; logic act_b, vb_b, fs_b, hs_b, vs_b;
  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .clk(clk), .rst(rst), .curr_x(x_b), .curr_y(y_b), .active_area(act_b),
    .vblank(vb_b), .frame_start(fs_b), .vga_hsync(hs_b), .vga_vsync(vs_b)
  );

  // small configuration: H_TOTAL=14, V_TOTAL=7, frame=98
  logic [10:0] x_c; logic [9:0] y_c; logic act_c, vb_c, fs_c, hs_c, vs_c;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1)
  ) u_sm (
    .clk(clk), .rst(rst_sm), .curr_x(x_c), .curr_y(y_c), .active_area(act_c),
    .vblank(vb_c), .frame_start(fs_c), .vga_hsync(hs_c), .vga_vsync(vs_c)
  );

  initial begin
    int lo_first_a = -1, lo_last_a = -1, lo_cnt_a = 0;
    int lo_first_b = -1, lo_last_b = -1, lo_cnt_b = 0;
    int act_cnt = 0, vs_hi_a = 0;
    int mism = 0, sm_act = 0, sm_vb = 0, sm_hlo = 0, sm_vhi = 0;
    int fs_cnt = 0, fs_prev = -1, fs_gap = 0;

    rst = 1'b1; rst_sm = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_x", x_a, 0);
    chk("rst_y", y_a, 0);
    chk("rst_active", act_a, 0);
    chk("rst_vblank", vb_a, 0);
    chk("rst_fstart", fs_a, 0);
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 0);
    chk("rst_d3_hsync", hs_b, 1);
    chk("rst_d3_vsync", vs_b, 0);
    chk("rst_sm_active", act_c, 0);

    // ---- default mode, first line ----
    rst = 1'b0;
    for (int n = 0; n <= 1680; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("rel_x", x_a, 0);
        chk("rel_y", y_a, 0);
        chk("rel_active", act_a, 1);
        chk("rel_fstart", fs_a, 1);
        chk("rel_vblank", vb_a, 0);
        chk("rel_hsync", hs_a, 1);
      end
      if (n == 1) chk("fstart_one_cycle", fs_a, 0);
      if (n == 1279) begin
        chk("x_1279", x_a, 1279);
        chk("act_at_1279", act_a, 1);
      end
      if (n == 1280) begin
        chk("x_1280", x_a, 1280);
        chk("act_drop_1280", act_a, 0);
      end
      if (n == 1680) begin
        chk("wrap_x", x_a, 0);
        chk("wrap_y", y_a, 1);
        chk("wrap_fstart", fs_a, 0);
      end
      if (n < 1680 && act_a) act_cnt++;
      if (vs_a) vs_hi_a++;
      if (!hs_a) begin
        if (lo_first_a < 0) lo_first_a = int'(x_a);
        lo_last_a = int'(x_a);
        lo_cnt_a++;
      end
      if (!hs_b) begin
        if (lo_first_b < 0) lo_first_b = int'(x_b);
        lo_last_b = int'(x_b);
        lo_cnt_b++;
      end
    end
    chk("line_active_cnt", act_cnt, 1280);
    chk("line0_vsync_hi", vs_hi_a, 0);
    chk("hs_first_low_x", lo_first_a, 1353);
    chk("hs_last_low_x", lo_last_a, 1480);
    chk("hs_low_cnt", lo_cnt_a, 128);
    chk("d3_first_low_x", lo_first_b, 1355);
    chk("d3_last_low_x", lo_last_b, 1482);
    chk("d3_low_cnt", lo_cnt_b, 128);

    // ---- small configuration ----
    rst_sm = 1'b0;
    for (int n = 0; n <= 277; n++) begin
      int ex, ey, px, py;
      logic hs_exp, vs_exp;
      @(negedge clk);
      ex = n % 14; ey = (n / 14) % 7;
      px = (n - 1) % 14; py = ((n - 1) / 14) % 7;
      hs_exp = (n >= 1 && px >= 10 && px <= 12) ? 1'b0 : 1'b1;
      vs_exp = (n >= 1 && py == 5) ? 1'b1 : 1'b0;
      if (int'(x_c) != ex || int'(y_c) != ey || act_c != (ex < 8 && ey < 4) ||
          vb_c != (ey >= 4) || fs_c != (ex == 0 && ey == 0) ||
          hs_c !== hs_exp || vs_c !== vs_exp) mism++;
      if (n < 98) begin
        if (act_c) sm_act++;
        if (vb_c) sm_vb++;
        if (!hs_c) sm_hlo++;
        if (vs_c) sm_vhi++;
      end
      if (fs_c) begin
        if (fs_prev >= 0) fs_gap = n - fs_prev;
        fs_prev = n;
        fs_cnt++;
      end
      if (n == 13) chk("sm_x_13", x_c, 13);
      if (n == 14) begin
        chk("sm_wrap_x", x_c, 0);
        chk("sm_wrap_y", y_c, 1);
      end
      if (n == 97) chk("sm_last_y", y_c, 6);
    end
    chk("sm_model_mism", mism, 0);
    chk("sm_active_cnt", sm_act, 32);
    chk("sm_vblank_cnt", sm_vb, 42);
    chk("sm_hs_low_cnt", sm_hlo, 21);
    chk("sm_vs_high_cnt", sm_vhi, 14);
    chk("sm_fstart_cnt", fs_cnt, 3);
    chk("sm_frame_period", fs_gap, 98);

    // ---- mid-frame reset inside both sync windows (x=11, y=5) ----
    chk("mid_pre_x", x_c, 11);
    chk("mid_pre_y", y_c, 5);
    chk("mid_pre_hsync", hs_c, 0);
    chk("mid_pre_vsync", vs_c, 1);
    rst_sm = 1'b1;
    #1;
    chk("mid_rst_x", x_c, 0);
    chk("mid_rst_y", y_c, 0);
    chk("mid_rst_hsync", hs_c, 1);
    chk("mid_rst_vsync", vs_c, 0);
    chk("mid_rst_active", act_c, 0);
    repeat (2) @(negedge clk);
    chk("mid_hold_hsync", hs_c, 1);
    rst_sm = 1'b0;
    @(negedge clk);
    chk("mid_rel_x", x_c, 0);
    chk("mid_rel_y", y_c, 0);
    chk("mid_rel_fstart", fs_c, 1);
    chk("mid_rel_active", act_c, 1);
    chk("mid_rel_hsync", hs_c, 1);
    repeat (11) @(negedge clk);
    chk("mid_x_11", x_c, 11);
    chk("mid_hsync_x11", hs_c, 0);
    repeat (3) @(negedge clk);
    chk("mid_wrap_x", x_c, 0);
    chk("mid_wrap_y", y_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster scan for the 1280x800 @ 60 Hz display: pixel/line counters, the `curr_x`/`curr_y`/`active_area` coordinate stream consumed by the renderer, and the hsync/vsync pulses driven to the connector. Sync outputs are delayed through a configurable pipeline so they stay aligned with the renderer's colour outputs. The block also provides `vblank` and `frame_start` so game logic can update the display field between frames.

## Interface
Parameters:
- `H_ACTIVE`, 1280: visible pixels per line.
- `H_FP`, 72: horizontal front porch, in pixels.
- `H_SYNC`, 128: hsync pulse width, in pixels.
- `H_BP`, 200: horizontal back porch; `H_TOTAL` = 1680.
- `V_ACTIVE`, 800: visible lines per frame.
- `V_FP`, 3: vertical front porch, in lines.
- `V_SYNC`, 6: vsync pulse width, in lines.
- `V_BP`, 22: vertical back porch; `V_TOTAL` = 831.
- `H_POL`, 0: hsync active level (0 = active-low).
- `V_POL`, 1: vsync active level (1 = active-high).
- `SYNC_DELAY`, 1: cycles of delay on `vga_hsync`/`vga_vsync`, range 0..7.

Ports:
- `clk` in 1: pixel clock, 83.5 MHz. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `curr_x` out 11: current horizontal position, 0..H_TOTAL-1.
- `curr_y` out 10: current vertical position, 0..V_TOTAL-1.
- `active_area` out 1: high when `curr_x` < H_ACTIVE and `curr_y` < V_ACTIVE.
- `vblank` out 1: high when `curr_y` >= V_ACTIVE.
- `frame_start` out 1: one-cycle pulse while (0,0) is presented.
- `vga_hsync` out 1: delayed hsync to the connector.
- `vga_vsync` out 1: delayed vsync to the connector.

## Operation
- **Horizontal counter:** `hc` counts 0..H_TOTAL-1. It wraps to 0 and increments `vc` at the same edge.
- **Vertical counter:** `vc` wraps 0..V_TOTAL-1. When the last pixel of the last line is followed by (0,0), `frame_start` asserts.
- **Sync windows (undelayed):**
  - hsync is active for `hc` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is active for `vc` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] across whole lines. vsync changes only when `hc` wraps.
- **Alignment:** all of `curr_x`, `curr_y`, `active_area`, `vblank` and `frame_start` are registered and mutually aligned. The flags describe the coordinate presented in the same cycle.
- **Sync delay:** `vga_hsync`/`vga_vsync` equal the undelayed sync for the coordinate presented SYNC_DELAY cycles earlier. With SYNC_DELAY = 0 they are combinational from the aligned registers.
- **Width rules:**
  - H_TOTAL must be <= 2048 and V_TOTAL <= 1024.
  - An elaboration-time `$error` fires if this is violated or if any porch/sync parameter is 0.
  - Comparisons are unsigned.

## Timing
- **Reset values:** while `rst` is high, `curr_x`=0, `curr_y`=0, `active_area`=0, `vblank`=0, `frame_start`=0. `vga_hsync`=~H_POL and `vga_vsync`=~V_POL, and every delay-stage register holds these inactive levels.
- **First edge after release:** the first rising edge of `clk` after `rst` falls presents (0,0) with `active_area`=1 and `frame_start`=1. An internal `started` flag separates this from the reset state.
- **Cycle N after release:** presents `curr_x` = N mod H_TOTAL.
- **Period:** one line is 1680 cycles, one frame is 1,396,080 cycles, and `frame_start` has exactly this period.
- **Mid-frame reset:** asynchronously forces the reset values. No partial frame or sync pulse continues, and the delay pipe is flushed to inactive levels.
- **Delayed sync after reset:** `vga_hsync`/`vga_vsync` first become active SYNC_DELAY cycles after the undelayed window opens.

## Structure
- Default timing constants go in GLOBAL.sv as `VGA_H_ACTIVE`, `VGA_H_FP`, etc., so the renderer and this block share one source for 1280x800.
- Sub-module `sync_delay`: a parameterised shift register (width 2, depth SYNC_DELAY, reset-to-value input) used for the hsync/vsync pipe.

## Test plan
- **Reset state:** assert `rst` for 5 cycles. Every output must hold its reset value; `vga_hsync`=1, `vga_vsync`=0.
- **Reset release:**
  - Release `rst` and check the first edge shows (0,0), `active_area`=1, `frame_start`=1.
  - `curr_x`=1279 is at cycle 1279.
  - `active_area` drops at `curr_x`=1280.
- **Full frame:** run one frame and check:
  - hsync low for exactly 128 cycles starting at `curr_x`=1352 (delayed by 1).
  - vsync high for 6 full lines starting at `curr_y`=803.
  - 1,024,000 `active_area` cycles.
  - `frame_start` pulses 1,396,080 cycles apart.
- **Mid-frame reset:** assert `rst` at `curr_x`=1400, `curr_y`=805, i.e. inside both sync windows. Syncs must go inactive immediately, and after release the scan restarts at (0,0).
- **Sync delay:** with SYNC_DELAY=3, the `vga_hsync` falling edge must occur exactly 3 cycles after `curr_x`=1352 is presented.
- **Small configuration:** H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1. Check wrap 13→0, `vblank` exactly for `curr_y` 4..6, and a frame period of 98 cycles.
